// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the cv32e40x writeback slice.
// Used by cv32e40x_wb_stage and cv32e40x_load_align.
package cv32e40x_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    WB_EMPTY,
    WB_HOLD,
    WB_WAIT_LOAD
  } wb_state_e;

  // Contents of the EX/WB slot.
  // The rd address is kept beside it because its width is a stage parameter.
  typedef struct packed {
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        is_load;
    logic [1:0]  data_size;
    logic        data_sign;
    logic [1:0]  addr_lsb;
  } ex_wb_pipe_t;

endpackage

// File: rtl/cv32e40x_load_align.sv
// Combinational load data extraction: shifts the bus word down to the addressed
// byte or half and applies sign/zero extension; words pass through unshifted.
module cv32e40x_load_align
  import cv32e40x_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [1:0]  addr_lsb_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {addr_lsb_i, 3'b000};
    data_o  = rdata_i;
    case (size_i)
      DSIZE_BYTE: data_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      DSIZE_HALF: data_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/cv32e40x_wb_stage.sv
// Writeback stage: one-instruction EX/WB slot, load response wait, RF write and retire.
// Optional 64-bit retire counter enabled by `define CV32E40X_WB_RETIRE_CNT_EN.
module cv32e40x_wb_stage
  import cv32e40x_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH         = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid_i,
  input  logic                          ex_rf_we_i,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ex_rf_waddr_i,
  input  logic [DATA_WIDTH-1:0]         ex_rf_wdata_i,
  input  logic                          ex_is_load_i,
  input  logic [1:0]                    ex_data_size_i,
  input  logic                          ex_data_sign_i,
  input  logic [1:0]                    ex_addr_lsb_i,
  input  logic                          lsu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         lsu_rdata_i,
  input  logic                          lsu_err_i,
  output logic                          wb_ready_o,
  output logic                          rf_we_wb_o,
  output logic [REGFILE_ADDR_WIDTH-1:0] rf_waddr_wb_o,
  output logic [DATA_WIDTH-1:0]         rf_wdata_wb_o,
  output logic                          wb_retire_o,
  output logic                          wb_err_o
`ifdef CV32E40X_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]                   retire_cnt_o
`endif
);

  wb_state_e                     state_q, state_d;
  ex_wb_pipe_t                   slot_q, slot_d;
  logic [REGFILE_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                          accept, load_done, complete, load_err;
  logic [31:0]                   load_data;

  cv32e40x_load_align u_load_align (
    .rdata_i    (lsu_rdata_i),
    .size_i     (slot_q.data_size),
    .sign_i     (slot_q.data_sign),
    .addr_lsb_i (slot_q.addr_lsb),
    .data_o     (load_data)
  );

  // A response arriving outside WAIT_LOAD never completes anything.
  always_comb begin
    load_done  = (state_q == WB_WAIT_LOAD) && lsu_rvalid_i;
    load_err   = load_done && lsu_err_i;
    complete   = (state_q == WB_HOLD) || load_done;
    wb_ready_o = (state_q == WB_EMPTY) || (state_q == WB_HOLD) || load_done;
    accept     = ex_valid_i && wb_ready_o;

    state_d = state_q;
    slot_d  = slot_q;
    waddr_d = waddr_q;
    if (accept) begin
      state_d = ex_is_load_i ? WB_WAIT_LOAD : WB_HOLD;
      slot_d  = '{rf_we:     ex_rf_we_i,
                  rf_wdata:  ex_rf_wdata_i,
                  is_load:   ex_is_load_i,
                  data_size: ex_data_size_i,
                  data_sign: ex_data_sign_i,
                  addr_lsb:  ex_addr_lsb_i};
      waddr_d = ex_rf_waddr_i;
    end else if (complete) begin
      state_d = WB_EMPTY;
    end
  end

  // x0 writes are dropped but the instruction still retires.
  always_comb begin
    wb_retire_o   = complete;
    wb_err_o      = load_err;
    rf_we_wb_o    = complete && slot_q.rf_we && !load_err && (waddr_q != '0);
    rf_waddr_wb_o = waddr_q;
    rf_wdata_wb_o = slot_q.is_load ? load_data : slot_q.rf_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_EMPTY;
      slot_q  <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      waddr_q <= waddr_d;
    end
  end

`ifdef CV32E40X_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + {63'd0, complete};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: tb/tb_cv32e40x_wb_stage.sv
// Scoreboard bench for cv32e40x_wb_stage: directed instructions push expected
// retirements into a queue that a negedge monitor pops and compares.
module tb_cv32e40x_wb_stage;
  import cv32e40x_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_rf_we_i = 1'b0;
  logic [4:0]  ex_rf_waddr_i = '0;
  logic [31:0] ex_rf_wdata_i = '0;
  logic        ex_is_load_i = 1'b0;
  logic [1:0]  ex_data_size_i = '0;
  logic        ex_data_sign_i = 1'b0;
  logic [1:0]  ex_addr_lsb_i = '0;
  logic        lsu_rvalid_i = 1'b0;
  logic [31:0] lsu_rdata_i = '0;
  logic        lsu_err_i = 1'b0;
  logic        wb_ready_o, rf_we_wb_o, wb_retire_o, wb_err_o;
  logic [4:0]  rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
`ifdef CV32E40X_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_o;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic allow_stray = 1'b0;
  logic model_wait = 1'b0;

  cv32e40x_wb_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid_i     (ex_valid_i),
    .ex_rf_we_i     (ex_rf_we_i),
    .ex_rf_waddr_i  (ex_rf_waddr_i),
    .ex_rf_wdata_i  (ex_rf_wdata_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_data_size_i (ex_data_size_i),
    .ex_data_sign_i (ex_data_sign_i),
    .ex_addr_lsb_i  (ex_addr_lsb_i),
    .lsu_rvalid_i   (lsu_rvalid_i),
    .lsu_rdata_i    (lsu_rdata_i),
    .lsu_err_i      (lsu_err_i),
    .wb_ready_o     (wb_ready_o),
    .rf_we_wb_o     (rf_we_wb_o),
    .rf_waddr_wb_o  (rf_waddr_wb_o),
    .rf_wdata_wb_o  (rf_wdata_wb_o),
    .wb_retire_o    (wb_retire_o),
`ifdef CV32E40X_WB_RETIRE_CNT_EN
    .retire_cnt_o   (retire_cnt_o),
`endif
    .wb_err_o       (wb_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every retirement must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (wb_retire_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_retire: got retire waddr=%0d expected none", rf_waddr_wb_o);
      end else begin
        e = exp_q.pop_front();
        check_val("retire_we", 64'(rf_we_wb_o), 64'(e.we));
        check_val("retire_waddr", 64'(rf_waddr_wb_o), 64'(e.waddr));
        check_val("retire_err", 64'(wb_err_o), 64'(e.err));
        if (e.we) check_val("retire_wdata", 64'(rf_wdata_wb_o), 64'(e.wdata));
      end
    end else if (rf_we_wb_o || wb_err_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL write_without_retire: got we=%0b err=%0b expected 0", rf_we_wb_o, wb_err_o);
    end
  end

  // Environment assertion: a load response only appears while a load is waiting.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_wait <= 1'b0;
    end else begin
      if (lsu_rvalid_i && !model_wait && !allow_stray) begin
        checks++;
        errors++;
        $display("[TB] FAIL stray_rvalid: got rvalid=1 expected 0 outside load wait");
      end
      if (ex_valid_i && (!model_wait || lsu_rvalid_i)) model_wait <= ex_is_load_i;
      else if (lsu_rvalid_i) model_wait <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input logic req, input string name);
    @(negedge clk);
    check_val(name, 64'(wb_ready_o), 64'(req));
  endtask

  task automatic apply_stimulus(input logic we, input logic [4:0] rd, input logic [31:0] wdata,
                                input logic ld, input logic [1:0] size, input logic sign,
                                input logic [1:0] lsb);
    ex_valid_i     = 1'b1;
    ex_rf_we_i     = we;
    ex_rf_waddr_i  = rd;
    ex_rf_wdata_i  = wdata;
    ex_is_load_i   = ld;
    ex_data_size_i = size;
    ex_data_sign_i = sign;
    ex_addr_lsb_i  = lsb;
  endtask

  task automatic ex_idle();
    ex_valid_i   = 1'b0;
    ex_is_load_i = 1'b0;
  endtask

  task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] d, input logic err);
    exp_t e;
    e.we = we; e.waddr = rd; e.wdata = d; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic lsu_resp(input logic v, input logic [31:0] d, input logic err);
    lsu_rvalid_i = v;
    lsu_rdata_i  = d;
    lsu_err_i    = err;
  endtask

  task automatic check_output(input string tag);
    @(negedge clk);
    check_val({tag, "_ready"}, 64'(wb_ready_o), 64'd1);
    check_val({tag, "_we"}, 64'(rf_we_wb_o), 64'd0);
    check_val({tag, "_waddr"}, 64'(rf_waddr_wb_o), 64'd0);
    check_val({tag, "_wdata"}, 64'(rf_wdata_wb_o), 64'd0);
    check_val({tag, "_retire"}, 64'(wb_retire_o), 64'd0);
    check_val({tag, "_err"}, 64'(wb_err_o), 64'd0);
`ifdef CV32E40X_WB_RETIRE_CNT_EN
    check_val({tag, "_cnt"}, retire_cnt_o, 64'd0);
`endif
  endtask

  initial begin
    check_output("reset");
    step();
    rst_n = 1'b1;
    step();

    // Three back-to-back ALU writes.
    apply_stimulus(1, 5'd1, 32'hA, 0, DSIZE_WORD, 0, 2'd0); push_exp(1, 5'd1, 32'hA, 0);
    check_ready(1, "alu1_ready"); step();
    apply_stimulus(1, 5'd2, 32'hB, 0, DSIZE_WORD, 0, 2'd0); push_exp(1, 5'd2, 32'hB, 0);
    check_ready(1, "alu2_ready"); step();
    apply_stimulus(1, 5'd3, 32'hC, 0, DSIZE_WORD, 0, 2'd0); push_exp(1, 5'd3, 32'hC, 0);
    check_ready(1, "alu3_ready"); step();
    ex_idle(); check_ready(1, "alu_drain_ready"); step();

    // LB, offset 2, response on the third wait cycle.
    apply_stimulus(1, 5'd4, 32'h0, 1, DSIZE_BYTE, 1, 2'd2); push_exp(1, 5'd4, 32'hFFFF_FFF0, 0);
    check_ready(1, "lb_accept_ready"); step();
    ex_idle(); check_ready(0, "lb_wait1_ready"); step();
    check_ready(0, "lb_wait2_ready"); step();
    lsu_resp(1, 32'h12F0_3456, 0); check_ready(1, "lb_resp_ready"); step();
    lsu_resp(0, 32'h0, 0);

    // LHU, offset 2, response in the first wait cycle.
    apply_stimulus(1, 5'd5, 32'h0, 1, DSIZE_HALF, 0, 2'd2); push_exp(1, 5'd5, 32'h0000_8001, 0);
    check_ready(1, "lhu_accept_ready"); step();
    ex_idle(); lsu_resp(1, 32'h8001_ABCD, 0); check_ready(1, "lhu_resp_ready"); step();
    lsu_resp(0, 32'h0, 0);

    // LW with bus error.
    apply_stimulus(1, 5'd6, 32'h0, 1, DSIZE_WORD, 0, 2'd0); push_exp(0, 5'd6, 32'h0, 1);
    check_ready(1, "lerr_accept_ready"); step();
    ex_idle(); lsu_resp(1, 32'hDEAD_BEEF, 1); check_ready(1, "lerr_resp_ready"); step();
    lsu_resp(0, 32'h0, 0);

    // Write to x0 retires without writing.
    apply_stimulus(1, 5'd0, 32'h55, 0, DSIZE_WORD, 0, 2'd0); push_exp(0, 5'd0, 32'h55, 0);
    check_ready(1, "x0_accept_ready"); step();
    ex_idle(); check_ready(1, "x0_drain_ready"); step();

    // ALU then LBU accepted in HOLD, then LH accepted as the LBU response returns.
    apply_stimulus(1, 5'd7, 32'h77, 0, DSIZE_WORD, 0, 2'd0); push_exp(1, 5'd7, 32'h77, 0);
    check_ready(1, "mix_alu_ready"); step();
    apply_stimulus(1, 5'd8, 32'h0, 1, DSIZE_BYTE, 0, 2'd3); push_exp(1, 5'd8, 32'h0000_00AB, 0);
    check_ready(1, "mix_lbu_accept_ready"); step();
    apply_stimulus(1, 5'd9, 32'h0, 1, DSIZE_HALF, 1, 2'd0); push_exp(1, 5'd9, 32'hFFFF_8001, 0);
    lsu_resp(1, 32'hAB12_3456, 0); check_ready(1, "mix_lh_accept_ready"); step();
    ex_idle(); lsu_resp(1, 32'h0001_8001, 0); check_ready(1, "mix_lh_resp_ready"); step();
    lsu_resp(0, 32'h0, 0);
    check_ready(1, "mix_idle_ready");
`ifdef CV32E40X_WB_RETIRE_CNT_EN
    check_val("retire_cnt", retire_cnt_o, 64'd10);
`endif
    step();

    // Reset while a load waits; the late response must be dropped.
    apply_stimulus(1, 5'd10, 32'h0, 1, DSIZE_WORD, 0, 2'd0);
    check_ready(1, "rst_load_accept_ready"); step();
    ex_idle(); rst_n = 1'b0;
    check_output("mid_reset");
    step();
    rst_n = 1'b1; allow_stray = 1'b1; lsu_resp(1, 32'h1234_5678, 0);
    check_output("post_reset");
    step();
    lsu_resp(0, 32'h0, 0); allow_stray = 1'b0;
    step(); step();

    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
